// File: rtl/n_term_pkg.sv
// Shared constants and types for the N-edge termination tile: loopback modes,
// group indices and the config field layout.
package n_term_pkg;

    typedef enum logic [1:0] {
        MODE_TIE     = 2'b00,
        MODE_DIRECT  = 2'b01,
        MODE_REG     = 2'b10,
        MODE_REG_INV = 2'b11
    } mode_t;

    localparam int NUM_GROUPS = 5;
    localparam int CFG_W      = 2 * NUM_GROUPS;

    localparam int G_N1    = 0;
    localparam int G_N2MID = 1;
    localparam int G_N2END = 2;
    localparam int G_N4    = 3;
    localparam int G_NN4   = 4;

    // Each group owns two adjacent config bits, group 0 in the LSBs.
    function automatic mode_t grp_mode(input logic [CFG_W-1:0] cfg, input int g);
        return mode_t'(cfg[2*g +: 2]);
    endfunction

endpackage

// File: rtl/n_term_loop_group.sv
// One loopback group: a free-running data register feeding a 4-way mode mux.
module n_term_loop_group
    import n_term_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  mode_t        mode_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] data_q;

    // Sampled every cycle regardless of mode so a switch into REG never shows stale data.
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= din_i;
    end

    always_comb begin
        dout_o = '0;
        unique case (mode_i)
            MODE_TIE:     dout_o = '0;
            MODE_DIRECT:  dout_o = din_i;
            MODE_REG:     dout_o = data_q;
            MODE_REG_INV: dout_o = ~data_q;
            default:      dout_o = '0;
        endcase
    end

endmodule

// File: rtl/n_term_param.sv
// North-edge termination tile: configurable loopback of southbound wires plus frame repeat.
// Optional macro N_TERM_ACTIVITY_EN adds an 8-bit saturating input-activity counter.
module n_term_param
    import n_term_pkg::*;
#(
    parameter int N1W             = 4,
    parameter int N2W             = 8,
    parameter int N4W             = 16,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int CFG_FRAME       = 0,
    parameter int STROBE_PIPE     = 1
) (
    input  logic                       UserCLK,
    input  logic                       rst,
    input  logic [N1W-1:0]             N1END,
    input  logic [N2W-1:0]             N2MID,
    input  logic [N2W-1:0]             N2END,
    input  logic [N4W-1:0]             N4END,
    input  logic [N4W-1:0]             NN4END,
    input  logic                       Ci,
    output logic [N1W-1:0]             S1BEG,
    output logic [N2W-1:0]             S2BEG,
    output logic [N2W-1:0]             S2BEGb,
    output logic [N4W-1:0]             S4BEG,
    output logic [N4W-1:0]             SS4BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo
`ifdef N_TERM_ACTIVITY_EN
    ,
    output logic [7:0]                 Activity
`endif
);

    logic             cfg_cap;
    logic [CFG_W-1:0] cfg_q, cfg_d;

    assign cfg_cap  = FrameStrobe[CFG_FRAME];
    assign UserCLKo = UserCLK;

    // Ci is a dead end at the array edge; fold it into a sink so it drives nothing.
    logic unused_ci;
    assign unused_ci = Ci;

    always_comb begin
        cfg_d = cfg_q;
        if (cfg_cap) cfg_d = FrameData[CFG_W-1:0];
    end

    always_ff @(posedge UserCLK) begin
        if (rst) cfg_q <= '0;
        else     cfg_q <= cfg_d;
    end

    n_term_loop_group #(.W(N1W)) u_g0 (
        .clk(UserCLK), .rst(rst), .mode_i(grp_mode(cfg_q, G_N1)),
        .din_i(N1END), .dout_o(S1BEG)
    );
    n_term_loop_group #(.W(N2W)) u_g1 (
        .clk(UserCLK), .rst(rst), .mode_i(grp_mode(cfg_q, G_N2MID)),
        .din_i(N2MID), .dout_o(S2BEG)
    );
    n_term_loop_group #(.W(N2W)) u_g2 (
        .clk(UserCLK), .rst(rst), .mode_i(grp_mode(cfg_q, G_N2END)),
        .din_i(N2END), .dout_o(S2BEGb)
    );
    n_term_loop_group #(.W(N4W)) u_g3 (
        .clk(UserCLK), .rst(rst), .mode_i(grp_mode(cfg_q, G_N4)),
        .din_i(N4END), .dout_o(S4BEG)
    );
    n_term_loop_group #(.W(N4W)) u_g4 (
        .clk(UserCLK), .rst(rst), .mode_i(grp_mode(cfg_q, G_NN4)),
        .din_i(NN4END), .dout_o(SS4BEG)
    );

    // Frame strobe/data repeater toward the next tile in the column.
    if (STROBE_PIPE == 0) begin : g_pass
        assign FrameStrobe_O = FrameStrobe;
        assign FrameData_O   = FrameData;
    end else begin : g_pipe
        logic [STROBE_PIPE-1:0][MaxFramesPerCol-1:0] strb_q;
        logic [STROBE_PIPE-1:0][FrameBitsPerRow-1:0] fdat_q;

        always_ff @(posedge UserCLK) begin
            if (rst) begin
                strb_q <= '0;
                fdat_q <= '0;
            end else begin
                strb_q[0] <= FrameStrobe;
                fdat_q[0] <= FrameData;
                for (int i = 1; i < STROBE_PIPE; i++) begin
                    strb_q[i] <= strb_q[i-1];
                    fdat_q[i] <= fdat_q[i-1];
                end
            end
        end

        assign FrameStrobe_O = strb_q[STROBE_PIPE-1];
        assign FrameData_O   = fdat_q[STROBE_PIPE-1];
    end

`ifdef N_TERM_ACTIVITY_EN
    localparam int ACT_W = N1W + 2*N2W + 2*N4W;

    logic [ACT_W-1:0] in_all, prev_q;
    logic [7:0]       act_q, act_d;
    logic             changed, act_clr;

    assign in_all  = {NN4END, N4END, N2END, N2MID, N1END};
    assign changed = |(in_all ^ prev_q);
    assign act_clr = cfg_cap & FrameData[CFG_W];

    always_comb begin
        act_d = act_q;
        if (act_clr)                       act_d = '0;
        else if (changed && act_q != 8'hFF) act_d = act_q + 8'd1;
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            prev_q <= '0;
            act_q  <= '0;
        end else begin
            prev_q <= in_all;
            act_q  <= act_d;
        end
    end

    assign Activity = act_q;
`endif

endmodule

// File: tb/tb_n_term_param.sv
// Directed self-checking bench for n_term_param (repeater built with STROBE_PIPE=2).
module tb_n_term_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  N1END;
    logic [7:0]  N2MID, N2END;
    logic [15:0] N4END, NN4END;
    logic        Ci;
    logic [3:0]  S1BEG;
    logic [7:0]  S2BEG, S2BEGb;
    logic [15:0] S4BEG, SS4BEG;
    logic [31:0] FrameData, FrameData_O;
    logic [19:0] FrameStrobe, FrameStrobe_O;
    logic        UserCLKo;
`ifdef N_TERM_ACTIVITY_EN
    logic [7:0]  Activity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    n_term_param #(.STROBE_PIPE(2)) dut (
        .UserCLK(clk), .rst(rst),
        .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END), .Ci(Ci),
        .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .FrameData_O(FrameData_O), .FrameStrobe_O(FrameStrobe_O), .UserCLKo(UserCLKo)
`ifdef N_TERM_ACTIVITY_EN
        , .Activity(Activity)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_s_zero(input string tag);
        chk({tag, ".S1"},  {28'd0, S1BEG},  32'd0);
        chk({tag, ".S2"},  {24'd0, S2BEG},  32'd0);
        chk({tag, ".S2b"}, {24'd0, S2BEGb}, 32'd0);
        chk({tag, ".S4"},  {16'd0, S4BEG},  32'd0);
        chk({tag, ".SS4"}, {16'd0, SS4BEG}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; Ci = 1'b0;
        N1END = '0; N2MID = '0; N2END = '0; N4END = '0; NN4END = '0;
        FrameData = '0; FrameStrobe = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk_all_s_zero("reset");
        chk("reset.FS_O", {12'd0, FrameStrobe_O}, 32'd0);
        chk("reset.FD_O", FrameData_O, 32'd0);
        @(negedge clk);
        chk("clkbuf", {31'd0, UserCLKo}, {31'd0, clk});
        @(posedge clk); #1;

        // All groups TIE after reset
        N1END = 4'hA; Ci = 1'b1;
        tick();
        chk_all_s_zero("tie");
`ifdef N_TERM_ACTIVITY_EN
        chk("act.first", {24'd0, Activity}, 32'd1);
`endif

        // Capture all-DIRECT; old mode still visible during capture cycle
        FrameStrobe = 20'h1; FrameData = 32'h155;
        #1 chk("cap.old_mode", {28'd0, S1BEG}, 32'd0);
        tick();
        FrameStrobe = '0; FrameData = '0;
        N2MID = 8'h3C; N2END = 8'h5A;
        #1;
        chk("direct.S2",  {24'd0, S2BEG},  32'h3C);
        chk("direct.S1",  {28'd0, S1BEG},  32'hA);
        chk("direct.S2b", {24'd0, S2BEGb}, 32'h5A);

        // G2 -> REG, G3 -> REG_INV, others TIE
        FrameStrobe = 20'h1; FrameData = 32'h0E0;
        tick();
        FrameStrobe = '0; FrameData = '0;
        N4END = 16'h00FF; N2END = 8'hA5;
        #1;
        chk("reg.switch_S2b", {24'd0, S2BEGb}, 32'h5A);
        chk("reginv.t_S4",    {16'd0, S4BEG},  32'hFFFF);
        chk("tie.S1_again",   {28'd0, S1BEG},  32'd0);
        tick();
        chk("reginv.t1_S4",   {16'd0, S4BEG},  32'hFF00);
        chk("reg.t1_S2b",     {24'd0, S2BEGb}, 32'hA5);

        // Non-config strobe: repeated 2 cycles later, cfg untouched
        FrameStrobe = 20'h80; FrameData = 32'hDEADBEEF;
        tick();
        FrameStrobe = '0; FrameData = '0;
        #1;
        chk("pipe.t1_FS", {12'd0, FrameStrobe_O}, 32'd0);
        tick();
        chk("pipe.t2_FS", {12'd0, FrameStrobe_O}, 32'h80);
        chk("pipe.t2_FD", FrameData_O, 32'hDEADBEEF);
        tick();
        chk("pipe.t3_FS", {12'd0, FrameStrobe_O}, 32'd0);
        chk("pipe.t3_FD", FrameData_O, 32'd0);
        chk("pipe.cfg_kept", {16'd0, S4BEG}, 32'hFF00);

        // Reset mid-pipeline drops the in-flight strobe
        FrameStrobe = 20'h80; FrameData = 32'h12345678;
        tick();
        FrameStrobe = '0; FrameData = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid.FS0", {12'd0, FrameStrobe_O}, 32'd0);
        chk("rstmid.FD0", FrameData_O, 32'd0);
        chk_all_s_zero("rstmid");
        tick();
        chk("rstmid.FS1", {12'd0, FrameStrobe_O}, 32'd0);
        tick();
        chk("rstmid.FS2", {12'd0, FrameStrobe_O}, 32'd0);

        // Reset wins over a simultaneous config capture
        N1END = 4'hF; N2MID = 8'hFF; N2END = 8'hFF; N4END = 16'hFFFF; NN4END = 16'hFFFF;
        rst = 1'b1; FrameStrobe = 20'h1; FrameData = 32'h3FF;
        tick();
        rst = 1'b0; FrameStrobe = '0; FrameData = '0;
        #1 chk_all_s_zero("rstwin.t1");
        tick();
        chk_all_s_zero("rstwin.t2");

        // G4 REG path: one-cycle delay
        FrameStrobe = 20'h1; FrameData = 32'h200;
        tick();
        FrameStrobe = '0; FrameData = '0;
        NN4END = 16'h1234;
        tick();
        NN4END = 16'h5678;
        #1 chk("reg.SS4_t1", {16'd0, SS4BEG}, 32'h1234);
        tick();
        chk("reg.SS4_t2", {16'd0, SS4BEG}, 32'h5678);

`ifdef N_TERM_ACTIVITY_EN
        for (int i = 0; i < 300; i++) begin
            N1END[0] = ~N1END[0];
            tick();
        end
        chk("act.sat", {24'd0, Activity}, 32'd255);
        FrameStrobe = 20'h1; FrameData = 32'h400;
        tick();
        FrameStrobe = '0; FrameData = '0;
        #1 chk("act.clr", {24'd0, Activity}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
